// File: rtl/csm_pkg.sv
// ============================================================================
// Module : csm_pkg
// Brief  : Shared types for the CSM two-port shared-memory responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package csm_pkg;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_HOLD  = 2'd2,
        CMD_RELSE = 2'd3
    } csm_cmd_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } csm_owner_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        HELD_A = 2'd1,
        HELD_B = 2'd2
    } csm_lock_state_t;

    // Initiator-side operation stream encoding: MSB selects the port.
    typedef enum logic [2:0] {
        OP_A_READ  = 3'd0,
        OP_A_WRITE = 3'd1,
        OP_A_HOLD  = 3'd2,
        OP_A_RELSE = 3'd3,
        OP_B_READ  = 3'd4,
        OP_B_WRITE = 3'd5,
        OP_B_HOLD  = 3'd6,
        OP_B_RELSE = 3'd7
    } operation_t;

    typedef struct packed {
        logic     port_b;
        csm_cmd_t cmd;
    } csm_req_t;

    function automatic csm_req_t op_to_req(input operation_t op);
        csm_req_t r;
        r.port_b = op[2];
        r.cmd    = csm_cmd_t'(op[1:0]);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csm_rr_arb.sv
// ============================================================================
// Module : csm_rr_arb
// Brief  : Two-requester round-robin arbiter; reset favours requester A.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module csm_rr_arb
    import csm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic prio_b_q;
    logic prio_b_d;

    always_comb begin
        gnt_a_o  = req_a_i && (!req_b_i || !prio_b_q);
        gnt_b_o  = req_b_i && !gnt_a_o;
        prio_b_d = prio_b_q;
        if (gnt_a_o) begin
            prio_b_d = 1'b1;
        end else if (gnt_b_o) begin
            prio_b_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/csm_shared_mem.sv
// ============================================================================
// Module : csm_shared_mem
// Brief  : Two-port responder sharing one memory, with hold/release lock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module csm_shared_mem
    import csm_pkg::*;
#(
    parameter int AW           = 4,
    parameter int DW           = 8,
    parameter int HOLD_TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  csm_cmd_t      a_cmd,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_err,
    output logic [DW-1:0] a_rdata,
    input  logic          b_valid,
    output logic          b_ready,
    input  csm_cmd_t      b_cmd,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_err,
    output logic [DW-1:0] b_rdata,
    output csm_owner_t    owner,
    output logic          timeout_evt
);

    localparam int CW        = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam int TO_LAST_I = (HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];
    localparam logic [CW-1:0] CNT_MAX = '1;

    csm_lock_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            evt_q, evt_d;
    logic            a_ack_q, a_err_q, b_ack_q, b_err_q;
    logic [DW-1:0]   a_rdata_q, b_rdata_q;
    logic [DW-1:0]   mem_q [2**AW];

    logic            elig_a, elig_b, gnt_a, gnt_b, accept, own_acc, err, to_hit;
    csm_cmd_t        cmd;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata, rd;

    // Writes and new holds from the non-owner stall; reads and releases pass.
    assign elig_a = a_valid && !(state_q == HELD_B && (a_cmd == CMD_WRITE || a_cmd == CMD_HOLD));
    assign elig_b = b_valid && !(state_q == HELD_A && (b_cmd == CMD_WRITE || b_cmd == CMD_HOLD));

    csm_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a_i (elig_a),
        .req_b_i (elig_b),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;
    assign accept  = gnt_a || gnt_b;
    assign cmd     = gnt_b ? b_cmd   : a_cmd;
    assign addr    = gnt_b ? b_addr  : a_addr;
    assign wdata   = gnt_b ? b_wdata : a_wdata;
    assign rd      = mem_q[addr];

    assign own_acc = (state_q == HELD_A && gnt_a) || (state_q == HELD_B && gnt_b);
    assign err     = accept && cmd == CMD_RELSE && !own_acc;
    assign to_hit  = (HOLD_TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        case (state_q)
            FREE: begin
                cnt_d = '0;
                if (accept && cmd == CMD_HOLD) begin
                    state_d = gnt_a ? HELD_A : HELD_B;
                end
            end
            HELD_A, HELD_B: begin
                // An owner request in the expiry cycle keeps the lock alive.
                if (own_acc) begin
                    cnt_d = '0;
                    if (cmd == CMD_RELSE) begin
                        state_d = FREE;
                    end
                end else if (to_hit) begin
                    state_d = FREE;
                    evt_d   = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = FREE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            evt_q     <= 1'b0;
            a_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
            a_ack_q <= gnt_a;
            a_err_q <= gnt_a && err;
            b_ack_q <= gnt_b;
            b_err_q <= gnt_b && err;
            if (gnt_a && cmd == CMD_READ) begin
                a_rdata_q <= rd;
            end
            if (gnt_b && cmd == CMD_READ) begin
                b_rdata_q <= rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && cmd == CMD_WRITE) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        case (state_q)
            HELD_A:  owner = OWN_A;
            HELD_B:  owner = OWN_B;
            default: owner = OWN_NONE;
        endcase
    end

    assign a_ack       = a_ack_q;
    assign a_err       = a_err_q;
    assign a_rdata     = a_rdata_q;
    assign b_ack       = b_ack_q;
    assign b_err       = b_err_q;
    assign b_rdata     = b_rdata_q;
    assign timeout_evt = evt_q;

endmodule

`default_nettype wire

// File: tb/tb_csm_shared_mem.sv
// ============================================================================
// Module : tb_csm_shared_mem
// Brief  : Directed self-checking bench for csm_shared_mem (HOLD_TIMEOUT=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_csm_shared_mem;
    import csm_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       a_ready, b_ready, a_ack, b_ack, a_err, b_err, timeout_evt;
    csm_cmd_t   a_cmd = CMD_READ, b_cmd = CMD_READ;
    logic [3:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0, a_rdata, b_rdata;
    csm_owner_t owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csm_shared_mem #(.AW(4), .DW(8), .HOLD_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_cmd(a_cmd), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_cmd(b_cmd), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .owner(owner), .timeout_evt(timeout_evt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (owner !== OWN_NONE) begin errors++; $display("FAIL rst_owner: got %0d exp %0d", owner, OWN_NONE); end
        checks++; if ({a_ack, b_ack, a_err, b_err, timeout_evt} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b exp 00000", {a_ack, b_ack, a_err, b_err, timeout_evt}); end
        checks++; if ({a_rdata, b_rdata} !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0000", {a_rdata, b_rdata}); end
        checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b exp 00", {a_ready, b_ready}); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        a_valid = 1'b1; a_cmd = CMD_WRITE; a_addr = 4'd3; a_wdata = 8'h5A;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b exp 1", a_ready); end
        tick();
        checks++; if ({a_ack, a_err} !== 2'b10) begin errors++; $display("FAIL wr_ack: got %b exp 10", {a_ack, a_err}); end
        a_cmd = CMD_READ;
        tick();
        a_valid = 1'b0;
        checks++; if ({a_ack, a_err} !== 2'b10) begin errors++; $display("FAIL rd_ack: got %b exp 10", {a_ack, a_err}); end
        checks++; if (a_rdata !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h exp 5a", a_rdata); end
        tick();
        checks++; if (a_ack !== 1'b0 || a_rdata !== 8'h5A) begin errors++; $display("FAIL rdata_hold: got ack %b data %h exp 0 5a", a_ack, a_rdata); end
    endtask

    task automatic test_back_to_back();
        // Last grant went to A, so B wins the first contention.
        a_valid = 1'b1; a_cmd = CMD_WRITE; a_addr = 4'd8; a_wdata = 8'hA8;
        b_valid = 1'b1; b_cmd = CMD_WRITE; b_addr = 4'd9; b_wdata = 8'hB9;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL b2b_arb0: got %b exp 01", {a_ready, b_ready}); end
        tick();
        b_valid = 1'b0;
        checks++; if (b_ack !== 1'b1) begin errors++; $display("FAIL b2b_back: got %b exp 1", b_ack); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_arb1: got %b exp 1", a_ready); end
        tick();
        checks++; if ({a_ack, b_ack} !== 2'b10) begin errors++; $display("FAIL b2b_aack: got %b exp 10", {a_ack, b_ack}); end
        a_cmd = CMD_READ; a_addr = 4'd9;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b1; b_cmd = CMD_READ; b_addr = 4'd8;
        checks++; if (a_rdata !== 8'hB9) begin errors++; $display("FAIL b2b_ard: got %h exp b9", a_rdata); end
        tick();
        b_valid = 1'b0;
        checks++; if (b_ack !== 1'b1 || b_rdata !== 8'hA8) begin errors++; $display("FAIL b2b_brd: got ack %b data %h exp 1 a8", b_ack, b_rdata); end
        tick();
    endtask

    task automatic test_hold_block();
        a_valid = 1'b1; a_cmd = CMD_HOLD;
        tick();
        a_valid = 1'b0;
        checks++; if (owner !== OWN_A || a_ack !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL hold_a: got own %0d ack %b err %b exp 1 1 0", owner, a_ack, a_err); end
        b_valid = 1'b1; b_cmd = CMD_WRITE; b_addr = 4'd1; b_wdata = 8'h11;
        #1;
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL hold_stall0: got %b exp 0", b_ready); end
        tick();
        a_valid = 1'b1; a_cmd = CMD_RELSE;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL hold_relse: got %b exp 10", {a_ready, b_ready}); end
        tick();
        a_valid = 1'b0;
        checks++; if (owner !== OWN_NONE || a_err !== 1'b0) begin errors++; $display("FAIL relse_own: got own %0d err %b exp 0 0", owner, a_err); end
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL hold_unstall: got %b exp 1", b_ready); end
        tick();
        b_valid = 1'b0;
        checks++; if (b_ack !== 1'b1) begin errors++; $display("FAIL hold_back: got %b exp 1", b_ack); end
        a_valid = 1'b1; a_cmd = CMD_READ; a_addr = 4'd1;
        tick();
        a_valid = 1'b0;
        checks++; if (a_rdata !== 8'h11) begin errors++; $display("FAIL hold_mem1: got %h exp 11", a_rdata); end
        tick();
    endtask

    task automatic test_contention();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_valid = 1'b1; a_cmd = CMD_HOLD;
        b_valid = 1'b1; b_cmd = CMD_HOLD;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL cont_hold: got %b exp 10", {a_ready, b_ready}); end
        tick();
        a_valid = 1'b0;
        checks++; if (owner !== OWN_A) begin errors++; $display("FAIL cont_owner: got %0d exp %0d", owner, OWN_A); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL cont_bstall: got %b exp 0", b_ready); end
        b_valid = 1'b0;
        tick();
        a_valid = 1'b1; a_cmd = CMD_RELSE;
        b_valid = 1'b1; b_cmd = CMD_READ; b_addr = 4'd3;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL cont_rr: got %b exp 01", {a_ready, b_ready}); end
        tick();
        b_valid = 1'b0;
        checks++; if (b_ack !== 1'b1 || b_rdata !== 8'h5A) begin errors++; $display("FAIL cont_brd: got ack %b data %h exp 1 5a", b_ack, b_rdata); end
        tick();
        a_valid = 1'b0;
        checks++; if (a_ack !== 1'b1 || a_err !== 1'b0 || owner !== OWN_NONE) begin errors++; $display("FAIL cont_rel: got ack %b err %b own %0d exp 1 0 0", a_ack, a_err, owner); end
        tick();
    endtask

    task automatic test_errors();
        b_valid = 1'b1; b_cmd = CMD_RELSE;
        tick();
        checks++; if ({b_ack, b_err} !== 2'b11 || owner !== OWN_NONE) begin errors++; $display("FAIL free_relse: got ack/err %b own %0d exp 11 0", {b_ack, b_err}, owner); end
        b_cmd = CMD_HOLD;
        tick();
        b_valid = 1'b0;
        checks++; if ({b_ack, b_err} !== 2'b10 || owner !== OWN_B) begin errors++; $display("FAIL hold_b: got ack/err %b own %0d exp 10 2", {b_ack, b_err}, owner); end
        a_valid = 1'b1; a_cmd = CMD_RELSE;
        tick();
        a_valid = 1'b0;
        checks++; if ({a_ack, a_err} !== 2'b11 || owner !== OWN_B) begin errors++; $display("FAIL foreign_relse: got ack/err %b own %0d exp 11 2", {a_ack, a_err}, owner); end
        b_valid = 1'b1; b_cmd = CMD_RELSE;
        tick();
        b_valid = 1'b0;
        checks++; if ({b_ack, b_err} !== 2'b10 || owner !== OWN_NONE) begin errors++; $display("FAIL relse_b: got ack/err %b own %0d exp 10 0", {b_ack, b_err}, owner); end
        tick();
    endtask

    task automatic test_timeout();
        logic [4:0] evt_seq;
        a_valid = 1'b1; a_cmd = CMD_HOLD;
        tick();
        a_valid = 1'b0;
        evt_seq = '0;
        for (int i = 0; i < 5; i++) begin
            evt_seq[i] = timeout_evt;
            if (i < 4) tick();
        end
        // Ack cycle is index 0; the pulse lands four cycles later.
        checks++; if (evt_seq !== 5'b10000) begin errors++; $display("FAIL to_pulse: got %b exp 10000", evt_seq); end
        checks++; if (owner !== OWN_NONE) begin errors++; $display("FAIL to_owner: got %0d exp 0", owner); end
        tick();
        checks++; if (timeout_evt !== 1'b0) begin errors++; $display("FAIL to_once: got %b exp 0", timeout_evt); end

        a_valid = 1'b1; a_cmd = CMD_HOLD;
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        a_valid = 1'b1; a_cmd = CMD_READ; a_addr = 4'd3;
        tick();
        a_valid = 1'b0;
        checks++; if (timeout_evt !== 1'b0 || owner !== OWN_A) begin errors++; $display("FAIL to_rescue: got evt %b own %0d exp 0 1", timeout_evt, owner); end
        checks++; if (a_ack !== 1'b1 || a_rdata !== 8'h5A) begin errors++; $display("FAIL to_read: got ack %b data %h exp 1 5a", a_ack, a_rdata); end
        a_valid = 1'b1; a_cmd = CMD_RELSE;
        tick();
        a_valid = 1'b0;
        checks++; if (owner !== OWN_NONE || timeout_evt !== 1'b0) begin errors++; $display("FAIL to_relse: got own %0d evt %b exp 0 0", owner, timeout_evt); end
        tick();
    endtask

    task automatic test_reset_mid();
        b_valid = 1'b1; b_cmd = CMD_HOLD;
        tick();
        b_cmd = CMD_WRITE; b_addr = 4'd2; b_wdata = 8'h22;
        checks++; if (owner !== OWN_B || b_ack !== 1'b1) begin errors++; $display("FAIL mid_pre: got own %0d ack %b exp 2 1", owner, b_ack); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (owner !== OWN_NONE || {a_ack, b_ack} !== 2'b00) begin errors++; $display("FAIL mid_async: got own %0d acks %b exp 0 00", owner, {a_ack, b_ack}); end
        tick();
        rst = 1'b0;
        b_valid = 1'b0;
        checks++; if (b_ack !== 1'b0) begin errors++; $display("FAIL mid_noack: got %b exp 0", b_ack); end
        a_valid = 1'b1; a_cmd = CMD_WRITE; a_addr = 4'd2; a_wdata = 8'h77;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL post_ready: got %b exp 1", a_ready); end
        tick();
        checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL post_ack: got %b exp 1", a_ack); end
        a_cmd = CMD_READ;
        tick();
        a_valid = 1'b0;
        checks++; if (a_rdata !== 8'h77) begin errors++; $display("FAIL post_read: got %h exp 77", a_rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_hold_block();
        test_contention();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
